logic_sequencer: RTL and testbench

LOGIC_SEQUENCER -- requirements
Module: logic_sequencer

---
 rtl/logic_sequencer.sv | 129 ++++++++++++
 tb/tb_logic_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_sequencer.sv
// Command sequencer in front of an external combinational logic unit: accepts a command, issues it, captures the result.
// Optional result chaining (alu_a sourced from the last result) is enabled by defining LOGIC_SEQUENCER_CHAIN_EN.
module logic_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [3:0] cmd_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_opcode,
    input  logic [7:0] alu_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_zero,
    output logic [7:0] op_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [3:0] alu_opcode_q, alu_opcode_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_zero_q, res_zero_d;
    logic [7:0] op_count_q, op_count_d;
    logic [7:0] a_src;
    logic       cmd_hs;
    logic       res_hs;

    assign cmd_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && res_ready);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign res_hs    = res_valid_q && res_ready;

`ifdef LOGIC_SEQUENCER_CHAIN_EN
    logic [7:0] chain_q, chain_d;

    // Forward the result completing this cycle so a back-to-back chained command sees it.
    assign chain_d = res_hs ? res_data_q : chain_q;
    assign a_src   = cmd_op[2] ? chain_d : cmd_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= 8'h00;
        end else begin
            chain_q <= chain_d;
        end
    end
`else
    assign a_src = cmd_a;
`endif

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_zero_d   = res_zero_q;
        op_count_d   = op_count_q;
        case (state_q)
            S_IDLE: begin
            end
            S_ISSUE: begin
                res_data_d  = alu_y;
                res_zero_d  = (alu_y == 8'h00);
                res_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (res_hs) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
        // A command accepted in RESP overrides the return to IDLE.
        if (cmd_hs) begin
            alu_a_d      = a_src;
            alu_b_d      = cmd_b;
            alu_opcode_d = cmd_op;
            state_d      = S_ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_opcode_q <= 4'h0;
            res_valid_q  <= 1'b0;
            res_data_q   <= 8'h00;
            res_zero_q   <= 1'b1;
            op_count_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_zero_q   <= res_zero_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_zero   = res_zero_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_logic_sequencer.sv
// Scoreboard bench for logic_sequencer: the bench plays the logic unit, predicts each result
// from the operation rules, and a negedge monitor checks handshakes, latency, holding and counting.
module tb_logic_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic [3:0] cmd_op = 4'h0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_zero;
    logic [7:0] op_count;

    logic_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // External logic unit
    always_comb begin
        case (alu_opcode[1:0])
            2'b00:   alu_y = alu_a & alu_b;
            2'b01:   alu_y = alu_a | alu_b;
            2'b10:   alu_y = alu_a ^ alu_b;
            default: alu_y = ~alu_a;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] exp;
        int         hs_cycle;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   model_count = 0;
    int   completed = 0;
    logic [7:0] chain_m = 8'h00;
    logic [7:0] last_res = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_result(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int r;
        case (op % 4)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            default: r = 255 - a;
        endcase
        return r[7:0];
    endfunction

    always @(posedge clk) cycle++;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            logic issuing;
            logic busy;
            issuing = (sb.size() != 0) && (sb[$].hs_cycle == cycle - 1);
            busy    = (sb.size() != 0) && !issuing;
            check("op_count", {24'd0, op_count}, model_count);
            check("cmd_ready", {31'd0, cmd_ready}, (sb.size() == 0) ? 1 : (issuing ? 0 : {31'd0, res_ready}));
            check("res_valid", {31'd0, res_valid}, {31'd0, busy});
            if (issuing) begin
                check("alu_a", {24'd0, alu_a}, {24'd0, sb[0].a});
                check("alu_b", {24'd0, alu_b}, {24'd0, sb[0].b});
                check("alu_opcode", {28'd0, alu_opcode}, {28'd0, sb[0].op});
            end
            if (busy && res_valid) begin
                check("res_data", {24'd0, res_data}, {24'd0, sb[0].exp});
                check("res_zero", {31'd0, res_zero}, {31'd0, (sb[0].exp == 8'h00)});
                if (res_ready) begin
                    last_res = res_data;
                    chain_m  = sb[0].exp;
                    void'(sb.pop_front());
                    model_count = (model_count + 1) % 256;
                    completed++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                txn_t t;
                t.a = cmd_a;
`ifdef LOGIC_SEQUENCER_CHAIN_EN
                if (cmd_op[2]) t.a = chain_m;
`endif
                t.b = cmd_b;
                t.op = cmd_op;
                t.exp = ref_result(t.a, t.b, t.op);
                t.hs_cycle = cycle;
                sb.push_back(t);
                $display("cmd  cyc=%0d a=%02h b=%02h op=%0h exp=%02h", cycle, t.a, t.b, t.op, t.exp);
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic ok;
        ok = 1'b0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (!ok) check("issue_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_alu_a"}, {24'd0, alu_a}, 0);
        check({tag, "_alu_b"}, {24'd0, alu_b}, 0);
        check({tag, "_alu_opcode"}, {28'd0, alu_opcode}, 0);
        check({tag, "_res_data"}, {24'd0, res_data}, 0);
        check({tag, "_res_zero"}, {31'd0, res_zero}, 1);
        check({tag, "_res_valid"}, {31'd0, res_valid}, 0);
        check({tag, "_op_count"}, {24'd0, op_count}, 0);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst0");
        rst = 1'b0;
        res_ready = 1'b1;

        // Basic operations
        issue(8'hF0, 8'h3C, 4'h0); drain();
        check("and_f0_3c", {24'd0, last_res}, 32'h30);
        check("count_after_first", {24'd0, op_count}, 1);
        issue(8'hF0, 8'h3C, 4'h1); drain();
        check("or_f0_3c", {24'd0, last_res}, 32'hFC);
        issue(8'hF0, 8'h3C, 4'h2); drain();
        check("xor_f0_3c", {24'd0, last_res}, 32'hCC);
        issue(8'hF0, 8'h3C, 4'h3); drain();
        check("inv_f0", {24'd0, last_res}, 32'h0F);
        issue(8'hAA, 8'h55, 4'h0); drain();
        check("and_zero", {24'd0, last_res}, 32'h00);
        check("res_zero_flag", {31'd0, res_zero}, 1);
        issue(8'h81, 8'h42, 4'h8); drain();
        check("op3_ignored", {24'd0, last_res}, 32'h00);

        // Chain
`ifdef LOGIC_SEQUENCER_CHAIN_EN
        issue(8'h0F, 8'hFF, 4'h1); drain();
        check("chain_seed", {24'd0, last_res}, 32'hFF);
        issue(8'h00, 8'h3C, 4'h4); drain();
        check("chain_and", {24'd0, last_res}, 32'h3C);
`else
        issue(8'h0F, 8'hFF, 4'h1); drain();
        check("chain_seed", {24'd0, last_res}, 32'hFF);
        issue(8'h00, 8'h3C, 4'h4); drain();
        check("nochain_and", {24'd0, last_res}, 32'h00);
`endif

        // Backpressure
        issue(8'h12, 8'h34, 4'h1);
        res_ready = 1'b0;
        cmd_a = 8'h5A; cmd_b = 8'h0F; cmd_op = 4'h2; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_cmd_ready", {31'd0, cmd_ready}, 0);
            if (i > 0) check("stall_res_data", {24'd0, res_data}, 32'h36);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("b2b_ready", {31'd0, cmd_ready}, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        drain();
        check("b2b_second", {24'd0, last_res}, 32'h55);

        // Reset during ISSUE
        issue(8'hFF, 8'hFF, 4'h0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        model_count = 0;
        chain_m = 8'h00;
        check_reset_values("rst_issue");
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 3) != 0);
            cmd_a  = 8'($urandom);
            cmd_b  = 8'($urandom);
            cmd_op = 4'($urandom);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        drain();

        // 256 back-to-back results wrap op_count
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        model_count = 0;
        chain_m = 8'h00;
        rst = 1'b0;
        completed = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 700 && completed < 256; i++) begin
            @(posedge clk); #1;
            cmd_a  = 8'($urandom);
            cmd_b  = 8'($urandom);
            cmd_op = 4'($urandom);
            if (completed == 255) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        drain();
        check("wrap_completed", completed, 256);
        check("wrap_op_count", {24'd0, op_count}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
